// File: rtl/lsu_pipe.sv
// Load/store unit: one access at a time, sign/zero-extended sub-word loads, read-modify-write sub-word stores.
// Optional feature: define LSU_MISALIGN_EXC_EN to fault misaligned accesses instead of truncating their offset.

module lsu_pipe #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_rd_en,
  output logic              dmem_wr_en,
  output logic [XLEN-1:0]   dmem_wr_data,
  input  logic [XLEN-1:0]   dmem_rd_data
);

  localparam int         OFF_W     = $clog2(XLEN / 8);
  localparam logic [1:0] LAST_CNT  = 2'(RD_LATENCY - 1);
  localparam logic [1:0] SIZE_FULL = (XLEN == 64) ? 2'b11 : 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_RMW_WAIT, S_WR, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d, uns_q, uns_d;
  logic [1:0]        size_q, size_d, cnt_q, cnt_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d, wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              accept, req_err, wait_done, sign;
  logic [OFF_W-1:0]  align_mask;
  logic [OFF_W+2:0]  shamt;
  logic [XLEN-1:0]   shifted, lane_mask, bit_mask, load_ext, merged;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign wait_done = (cnt_q == LAST_CNT);

  always_comb begin
    case (req_size)
      2'b00:   align_mask = '0;
      2'b01:   align_mask = OFF_W'(1);
      2'b10:   align_mask = OFF_W'(3);
      default: align_mask = OFF_W'(7);
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  assign req_err = ((XLEN == 32) && (req_size == 2'b11)) ||
                   ((req_addr[OFF_W-1:0] & align_mask) != '0);
`else
  assign req_err = (XLEN == 32) && (req_size == 2'b11);
`endif

  // Lane datapath works on the registered request; the same lane mask drives load extension and store merge.
  assign shamt   = {off_q, 3'b000};
  assign shifted = dmem_rd_data >> shamt;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    lane_mask = '1;
    sign      = shifted[XLEN-1];
    case (size_q)
      2'b00:   begin lane_mask = XLEN'(8'hFF);         sign = shifted[7];  end
      2'b01:   begin lane_mask = XLEN'(16'hFFFF);      sign = shifted[15]; end
      2'b10:   begin lane_mask = XLEN'(32'hFFFF_FFFF); sign = shifted[31]; end
      default: ;
    endcase
  end

  assign load_ext = (shifted & lane_mask) | ((!uns_q && sign) ? ~lane_mask : '0);
  assign bit_mask = lane_mask << shamt;
  assign merged   = (dmem_rd_data & ~bit_mask) | ((wdata_q << shamt) & bit_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      cnt_q        <= 2'd0;
      off_q        <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      addr_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      write_q      <= write_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      addr_q       <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                               state_d = S_RESP;
          else if (req_write && req_size == SIZE_FULL) state_d = S_WR;
          else                                       state_d = S_RD;
        end
      end
      S_RD:       state_d = write_q ? S_RMW_WAIT : S_RD_WAIT;
      S_RD_WAIT:  if (wait_done) state_d = S_RESP;
      S_RMW_WAIT: if (wait_done) state_d = S_WR;
      S_WR:       state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    if (accept) begin
      write_d = req_write;
      size_d  = req_size;
      uns_d   = req_unsigned;
      off_d   = req_addr[OFF_W-1:0] & ~align_mask;
      wdata_d = req_wdata;
      // Faulted requests leave the memory address untouched.
      if (state_d != S_RESP) addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    cnt_d        = (state_q == S_RD_WAIT || state_q == S_RMW_WAIT) ? cnt_q + 2'd1 : 2'd0;
    rd_en_d      = (state_d == S_RD);
    wr_en_d      = (state_d == S_WR);
    resp_valid_d = (state_d == S_RESP);
    resp_err_d   = accept && req_err;
    resp_rdata_d = (state_q == S_RD_WAIT && wait_done) ? load_ext : '0;

    wr_data_d = '0;
    if (accept && state_d == S_WR)             wr_data_d = req_wdata;
    else if (state_q == S_RMW_WAIT && wait_done) wr_data_d = merged;
  end

  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  assign dmem_rd_en   = rd_en_q;
  assign dmem_wr_en   = wr_en_q;
  assign dmem_wr_data = wr_data_q;
  assign dmem_addr    = addr_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: a 32-bit/latency-1 instance and a 64-bit/latency-3 instance, each with a latency-accurate memory model.

module tb_lsu_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 32-bit instance, RD_LATENCY=1
  logic        a_req_valid = 1'b0, a_req_write = 1'b0, a_req_unsigned = 1'b0;
  logic [1:0]  a_req_size = 2'b00;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic        a_req_ready, a_resp_valid, a_resp_err, a_dmem_rd_en, a_dmem_wr_en;
  logic [31:0] a_resp_rdata, a_dmem_addr, a_dmem_wr_data, a_dmem_rd_data;

  // 64-bit instance, RD_LATENCY=3
  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_req_unsigned = 1'b0;
  logic [1:0]  b_req_size = 2'b00;
  logic [31:0] b_req_addr = '0;
  logic [63:0] b_req_wdata = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_dmem_rd_en, b_dmem_wr_en;
  logic [63:0] b_resp_rdata, b_dmem_wr_data, b_dmem_rd_data;
  logic [31:0] b_dmem_addr;

  lsu_pipe #(.XLEN(32), .ADDR_W(32), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_write(a_req_write), .req_size(a_req_size), .req_unsigned(a_req_unsigned),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .dmem_addr(a_dmem_addr),
    .dmem_rd_en(a_dmem_rd_en), .dmem_wr_en(a_dmem_wr_en), .dmem_wr_data(a_dmem_wr_data),
    .dmem_rd_data(a_dmem_rd_data)
  );

  lsu_pipe #(.XLEN(64), .ADDR_W(32), .RD_LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .dmem_addr(b_dmem_addr),
    .dmem_rd_en(b_dmem_rd_en), .dmem_wr_en(b_dmem_wr_en), .dmem_wr_data(b_dmem_wr_data),
    .dmem_rd_data(b_dmem_rd_data)
  );

  // Memory models: read data is valid only RD_LATENCY cycles after the strobe, poison otherwise.
  logic [31:0] mem_a [256];
  logic [63:0] mem_b [16];
  logic        mem_ready = 1'b0;
  logic        a_rp = 1'b0;
  logic [7:0]  a_ri = '0;
  logic [2:0]  b_rp = '0;
  logic [3:0]  b_ri [3] = '{4'd0, 4'd0, 4'd0};

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= '0;
      for (int i = 0; i < 16; i++) mem_b[i] <= '0;
      mem_a[8'h40] <= 32'h8899_AABB;
      mem_b[4'h0]  <= 64'h8000_0000_0000_0001;
      mem_ready    <= 1'b1;
    end else begin
      if (a_dmem_wr_en) mem_a[a_dmem_addr[9:2]] <= a_dmem_wr_data;
      if (b_dmem_wr_en) mem_b[b_dmem_addr[6:3]] <= b_dmem_wr_data;
    end
    a_rp    <= a_dmem_rd_en;
    a_ri    <= a_dmem_addr[9:2];
    b_rp    <= {b_rp[1:0], b_dmem_rd_en};
    b_ri[0] <= b_dmem_addr[6:3];
    b_ri[1] <= b_ri[0];
    b_ri[2] <= b_ri[1];
  end

  assign a_dmem_rd_data = a_rp    ? mem_a[a_ri]    : 32'hDEAD_DEAD;
  assign b_dmem_rd_data = b_rp[2] ? mem_b[b_ri[2]] : 64'hDEAD_DEAD_DEAD_DEAD;

  // Uniform view of both instances for the monitor and the checks.
  logic [1:0]  m_rd, m_wr, m_rv, m_err, m_rdy;
  logic [63:0] m_rdata [2];
  logic [63:0] m_wdata [2];
  logic [63:0] m_addr  [2];
  assign m_rd  = {b_dmem_rd_en, a_dmem_rd_en};
  assign m_wr  = {b_dmem_wr_en, a_dmem_wr_en};
  assign m_rv  = {b_resp_valid, a_resp_valid};
  assign m_err = {b_resp_err, a_resp_err};
  assign m_rdy = {b_req_ready, a_req_ready};
  assign m_rdata[0] = {32'h0, a_resp_rdata};
  assign m_rdata[1] = b_resp_rdata;
  assign m_wdata[0] = {32'h0, a_dmem_wr_data};
  assign m_wdata[1] = b_dmem_wr_data;
  assign m_addr[0]  = {32'h0, a_dmem_addr};
  assign m_addr[1]  = {32'h0, b_dmem_addr};

  int          rd_cnt [2] = '{0, 0};
  int          wr_cnt [2] = '{0, 0};
  int          rv_cnt [2] = '{0, 0};
  int          rd_cyc [2] = '{0, 0};
  int          wr_cyc [2] = '{0, 0};
  int          rv_cyc [2] = '{0, 0};
  int          overlap [2] = '{0, 0};
  int          bad_wd [2] = '{0, 0};
  logic [63:0] rd_addr [2];
  logic [63:0] wr_addr [2];
  logic [63:0] wr_data [2];
  logic [63:0] rv_data [2];
  logic        rv_err [2];
  logic        prev_rv [2] = '{1'b0, 1'b0};
  logic        rdy_after [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_rd[i]) begin
        rd_cnt[i]  <= rd_cnt[i] + 1;
        rd_cyc[i]  <= cyc;
        rd_addr[i] <= m_addr[i];
      end
      if (m_wr[i]) begin
        wr_cnt[i]  <= wr_cnt[i] + 1;
        wr_cyc[i]  <= cyc;
        wr_addr[i] <= m_addr[i];
        wr_data[i] <= m_wdata[i];
      end
      if (m_rv[i]) begin
        rv_cnt[i]  <= rv_cnt[i] + 1;
        rv_cyc[i]  <= cyc;
        rv_data[i] <= m_rdata[i];
        rv_err[i]  <= m_err[i];
      end
      if (m_rd[i] && m_wr[i]) overlap[i] <= overlap[i] + 1;
      if (!m_wr[i] && m_wdata[i] != 64'h0) bad_wd[i] <= bad_wd[i] + 1;
      prev_rv[i] <= m_rv[i];
      if (prev_rv[i]) rdy_after[i] <= m_rdy[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int base_rd [2];
  int base_wr [2];
  int base_rv [2];

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      base_rd[i] = rd_cnt[i];
      base_wr[i] = wr_cnt[i];
      base_rv[i] = rv_cnt[i];
    end
  endtask

  // Presents one request, returns its accept cycle; leaves the caller at the negedge of cycle c+1.
  task automatic issue(input int d, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] addr, input logic [63:0] wd, output int c);
    int n;
    snap();
    @(negedge clk);
    if (d == 0) begin
      a_req_write = wr; a_req_size = sz; a_req_unsigned = un;
      a_req_addr = addr; a_req_wdata = wd[31:0]; a_req_valid = 1'b1;
    end else begin
      b_req_write = wr; b_req_size = sz; b_req_unsigned = un;
      b_req_addr = addr; b_req_wdata = wd; b_req_valid = 1'b1;
    end
    n = 0;
    while (!m_rdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 64'(n < 20), 64'd1);
    c = cyc;
    @(negedge clk);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    check("busy_ready", 64'(m_rdy[d]), 64'd0);
  endtask

  task automatic run(input int d, input logic wr, input logic [1:0] sz, input logic un,
                     input logic [31:0] addr, input logic [63:0] wd, output int c);
    issue(d, wr, sz, un, addr, wd, c);
    repeat (10) @(negedge clk);
  endtask

  task automatic expect_txn(input string tag, input int d, input int c, input int n_rd,
                            input int n_wr, input logic [63:0] exp_addr, input int wr_off,
                            input logic [63:0] exp_wd, input int rv_off,
                            input logic [63:0] exp_rdata, input logic exp_err);
    check({tag, ".rd_n"}, 64'(rd_cnt[d] - base_rd[d]), 64'(n_rd));
    if (n_rd > 0) begin
      check({tag, ".rd_cyc"}, 64'(rd_cyc[d] - c), 64'd1);
      check({tag, ".rd_addr"}, rd_addr[d], exp_addr);
    end
    check({tag, ".wr_n"}, 64'(wr_cnt[d] - base_wr[d]), 64'(n_wr));
    if (n_wr > 0) begin
      check({tag, ".wr_cyc"}, 64'(wr_cyc[d] - c), 64'(wr_off));
      check({tag, ".wr_addr"}, wr_addr[d], exp_addr);
      check({tag, ".wr_data"}, wr_data[d], exp_wd);
    end
    check({tag, ".resp_n"}, 64'(rv_cnt[d] - base_rv[d]), 64'd1);
    check({tag, ".resp_cyc"}, 64'(rv_cyc[d] - c), 64'(rv_off));
    check({tag, ".rdata"}, rv_data[d], exp_rdata);
    check({tag, ".err"}, 64'(rv_err[d]), 64'(exp_err));
    check({tag, ".ready_after"}, 64'(rdy_after[d]), 64'd1);
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        un;
    logic [31:0] addr;
    logic [63:0] exp;
  } ld_t;

  ld_t lds_a [7];
  ld_t lds_b [4];

  initial begin
    int c;

    lds_a[0] = '{2'b00, 1'b0, 32'h103, 64'hFFFF_FF88};
    lds_a[1] = '{2'b00, 1'b1, 32'h103, 64'h0000_0088};
    lds_a[2] = '{2'b01, 1'b0, 32'h102, 64'hFFFF_8899};
    lds_a[3] = '{2'b01, 1'b1, 32'h100, 64'h0000_AABB};
    lds_a[4] = '{2'b00, 1'b0, 32'h101, 64'hFFFF_FFAA};
    lds_a[5] = '{2'b00, 1'b1, 32'h102, 64'h0000_0099};
    lds_a[6] = '{2'b10, 1'b0, 32'h100, 64'h8899_AABB};

    lds_b[0] = '{2'b10, 1'b0, 32'h4, 64'hFFFF_FFFF_8000_0000};
    lds_b[1] = '{2'b10, 1'b1, 32'h4, 64'h0000_0000_8000_0000};
    lds_b[2] = '{2'b11, 1'b0, 32'h0, 64'h8000_0000_0000_0001};
    lds_b[3] = '{2'b00, 1'b0, 32'h7, 64'hFFFF_FFFF_FFFF_FF80};

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst.req_ready", 64'(m_rdy[i]), 64'd1);
      check("rst.resp_valid", 64'(m_rv[i]), 64'd0);
      check("rst.resp_err", 64'(m_err[i]), 64'd0);
      check("rst.resp_rdata", m_rdata[i], 64'd0);
      check("rst.rd_en", 64'(m_rd[i]), 64'd0);
      check("rst.wr_en", 64'(m_wr[i]), 64'd0);
      check("rst.wr_data", m_wdata[i], 64'd0);
      check("rst.dmem_addr", m_addr[i], 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loads on the 32-bit instance, word 0x8899AABB at 0x100
    for (int i = 0; i < 7; i++) begin
      run(0, 1'b0, lds_a[i].sz, lds_a[i].un, lds_a[i].addr, 64'h0, c);
      expect_txn($sformatf("a_ld%0d", i), 0, c, 1, 0, 64'h100, 0, 64'h0, 3, lds_a[i].exp, 1'b0);
    end

    // Sub-word store via read-modify-write, then read back
    run(0, 1'b1, 2'b01, 1'b0, 32'h102, 64'h1234, c);
    expect_txn("a_sh", 0, c, 1, 1, 64'h100, 3, 64'h1234_AABB, 4, 64'h0, 1'b0);
    run(0, 1'b0, 2'b10, 1'b0, 32'h100, 64'h0, c);
    expect_txn("a_lw_after_sh", 0, c, 1, 0, 64'h100, 0, 64'h0, 3, 64'h1234_AABB, 1'b0);

    // Full-word store, then a byte store merging into it
    run(0, 1'b1, 2'b10, 1'b0, 32'h104, 64'hDEAD_BEEF, c);
    expect_txn("a_sw", 0, c, 0, 1, 64'h104, 1, 64'hDEAD_BEEF, 2, 64'h0, 1'b0);
    run(0, 1'b1, 2'b00, 1'b0, 32'h105, 64'h5A, c);
    expect_txn("a_sb", 0, c, 1, 1, 64'h104, 3, 64'hDEAD_5AEF, 4, 64'h0, 1'b0);

    // Misaligned word load
    run(0, 1'b0, 2'b10, 1'b0, 32'h102, 64'h0, c);
`ifdef LSU_MISALIGN_EXC_EN
    expect_txn("a_lw_mis", 0, c, 0, 0, 64'h0, 0, 64'h0, 1, 64'h0, 1'b1);
`else
    expect_txn("a_lw_mis", 0, c, 1, 0, 64'h100, 0, 64'h0, 3, 64'h1234_AABB, 1'b0);
`endif

    // Doubleword on a 32-bit LSU faults; dmem_addr keeps its last value
    run(0, 1'b0, 2'b11, 1'b0, 32'h100, 64'h0, c);
    expect_txn("a_ld_illegal", 0, c, 0, 0, 64'h0, 0, 64'h0, 1, 64'h0, 1'b1);
`ifdef LSU_MISALIGN_EXC_EN
    check("a_addr_hold", m_addr[0], 64'h104);
`else
    check("a_addr_hold", m_addr[0], 64'h100);
`endif

    // 64-bit instance, latency 3
    for (int i = 0; i < 4; i++) begin
      run(1, 1'b0, lds_b[i].sz, lds_b[i].un, lds_b[i].addr, 64'h0, c);
      expect_txn($sformatf("b_ld%0d", i), 1, c, 1, 0, 64'h0, 0, 64'h0, 5, lds_b[i].exp, 1'b0);
    end
    run(1, 1'b1, 2'b00, 1'b0, 32'h6, 64'hAB, c);
    expect_txn("b_sb", 1, c, 1, 1, 64'h0, 5, 64'h80AB_0000_0000_0001, 6, 64'h0, 1'b0);
    run(1, 1'b1, 2'b11, 1'b0, 32'h8, 64'h1122_3344_5566_7788, c);
    expect_txn("b_sd", 1, c, 0, 1, 64'h8, 1, 64'h1122_3344_5566_7788, 2, 64'h0, 1'b0);
    run(1, 1'b0, 2'b11, 1'b0, 32'h8, 64'h0, c);
    expect_txn("b_ld_after_sd", 1, c, 1, 0, 64'h8, 0, 64'h0, 5, 64'h1122_3344_5566_7788, 1'b0);

    // Reset pulsed during RMW_WAIT aborts the store
    issue(0, 1'b1, 2'b00, 1'b0, 32'h100, 64'h77, c);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rmw_rst.ready_in_reset", 64'(m_rdy[0]), 64'd1);
    check("rmw_rst.wr_data_in_reset", m_wdata[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rmw_rst.rd_n", 64'(rd_cnt[0] - base_rd[0]), 64'd1);
    check("rmw_rst.wr_n", 64'(wr_cnt[0] - base_wr[0]), 64'd0);
    check("rmw_rst.resp_n", 64'(rv_cnt[0] - base_rv[0]), 64'd0);
    check("rmw_rst.ready", 64'(m_rdy[0]), 64'd1);
    run(0, 1'b0, 2'b10, 1'b0, 32'h100, 64'h0, c);
    expect_txn("a_lw_after_rst", 0, c, 1, 0, 64'h100, 0, 64'h0, 3, 64'h1234_AABB, 1'b0);

    // Strobe exclusivity and idle write data over the whole run
    for (int i = 0; i < 2; i++) begin
      check($sformatf("strobe_overlap%0d", i), 64'(overlap[i]), 64'd0);
      check($sformatf("idle_wr_data%0d", i), 64'(bad_wd[i]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
